ingress_filter_stage: RTL

- Parametrised router ingress stage on the AXI-Stream datapath, between the RX queues and output-port lookup.
- Buffers frames in a fall-through FIFO and drives them out through a registered output stage with full TREADY back-pressure.
- Parses the first two beats of each frame: MAC filtering, IPv4 detection, and destination-IP table match.
- Holds a register-accessible destination-IP table and four 32-bit statistics counters.

---
 rtl/ingress_filter_stage.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/ingress_filter_stage.sv
// Router ingress stage: fall-through FIFO, registered AXI-Stream output, header parser,
// destination-IP table and statistics. Optional macro DROP_WRONG_MAC_EN discards MAC-check failures.
module ingress_filter_stage #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXI_DATA_WIDTH   = 32,
  parameter int FIFO_DEPTH_BITS      = 2,
  parameter int TBL_ADDR_WIDTH       = 5,
  parameter int NUM_PORTS            = 4,
  parameter int SRC_PORT_POS         = 16
) (
  input  logic                              AXI_ACLK,
  input  logic                              AXI_RESET,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S_AXIS_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
  input  logic                              S_AXIS_TVALID,
  input  logic                              S_AXIS_TLAST,
  output logic                              S_AXIS_TREADY,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
  output logic                              M_AXIS_TVALID,
  output logic                              M_AXIS_TLAST,
  input  logic                              M_AXIS_TREADY,
  input  logic [48*NUM_PORTS-1:0]           mac_addr,
  input  logic                              counter_clear,
  input  logic                              tbl_rd_req,
  input  logic                              tbl_wr_req,
  input  logic [TBL_ADDR_WIDTH-1:0]         tbl_rd_addr,
  input  logic [TBL_ADDR_WIDTH-1:0]         tbl_wr_addr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     tbl_wr_data,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     tbl_rd_data,
  output logic                              tbl_rd_ack,
  output logic                              tbl_wr_ack,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     pkt_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     wrong_mac_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     non_ip_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     dest_hit_count
);
  localparam int DW     = C_S_AXIS_DATA_WIDTH;
  localparam int UW     = C_S_AXIS_TUSER_WIDTH;
  localparam int AW     = C_S_AXI_DATA_WIDTH;
  localparam int DEPTH  = 2**FIFO_DEPTH_BITS;
  localparam int TBL_N  = 2**TBL_ADDR_WIDTH;
  localparam int BEAT_W = DW + DW/8 + UW + 1;
  localparam logic [FIFO_DEPTH_BITS:0] NF_LVL = (FIFO_DEPTH_BITS+1)'(DEPTH-1);

  typedef enum logic [1:0] {HDR0, HDR1, BODY} state_t;
  state_t r_state, w_state_nxt;

  logic [BEAT_W-1:0]          r_mem [DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] r_wr_ptr, r_rd_ptr;
  logic [FIFO_DEPTH_BITS:0]   r_count;
  logic                       w_empty, w_nearly_full, w_push, w_pop, w_load, w_drop;
  logic [DW-1:0]              w_hd_data;
  logic [DW/8-1:0]            w_hd_strb;
  logic [UW-1:0]              w_hd_user;
  logic                       w_hd_last;

  logic                       r_m_valid;
  logic [AW-1:0]              r_tbl [TBL_N];
  logic                       r_mac_ok, r_is_ip;
  logic [15:0]                r_dip_hi;
  logic [47:0]                w_dst_mac;
  logic [7:0]                 w_src_sel;
  logic [2:0]                 w_src_idx;
  logic                       w_src_found, w_port_ok, w_mac_hit, w_mac_ok, w_is_ip, w_dip_hit;
  logic [31:0]                w_dip;
  logic                       w_inc_pkt, w_inc_wrong, w_inc_nonip, w_inc_hit;

  // FIFO never fills completely: ready drops one entry early so a beat in flight always fits
  assign w_empty       = (r_count == '0);
  assign w_nearly_full = (r_count >= NF_LVL);
  assign S_AXIS_TREADY = !w_nearly_full;
  assign w_push        = S_AXIS_TVALID && !w_nearly_full;
  assign {w_hd_last, w_hd_user, w_hd_strb, w_hd_data} = r_mem[r_rd_ptr];

`ifdef DROP_WRONG_MAC_EN
  assign w_drop = !w_empty && ((r_state == HDR0) ? !w_mac_ok : !r_mac_ok);
`else
  assign w_drop = 1'b0;
`endif
  assign w_load = !w_empty && !w_drop && (!r_m_valid || M_AXIS_TREADY);
  assign w_pop  = w_load || w_drop;

  always_ff @(posedge AXI_ACLK) begin
    if (w_push) r_mem[r_wr_ptr] <= {S_AXIS_TLAST, S_AXIS_TUSER, S_AXIS_TSTRB, S_AXIS_TDATA};
  end

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_RESET) begin
      r_m_valid    <= 1'b0;
      M_AXIS_TDATA <= '0;
      M_AXIS_TSTRB <= '0;
      M_AXIS_TUSER <= '0;
      M_AXIS_TLAST <= 1'b0;
    end else if (w_load) begin
      r_m_valid    <= 1'b1;
      M_AXIS_TDATA <= w_hd_data;
      M_AXIS_TSTRB <= w_hd_strb;
      M_AXIS_TUSER <= w_hd_user;
      M_AXIS_TLAST <= w_hd_last;
    end else if (M_AXIS_TREADY) begin
      r_m_valid <= 1'b0;
    end
  end
  assign M_AXIS_TVALID = r_m_valid;

  assign w_dst_mac = w_hd_data[255:208];
  assign w_src_sel = w_hd_user[SRC_PORT_POS +: 8];
  assign w_is_ip   = (w_hd_data[159:144] == 16'h0800) && (w_hd_data[143:140] == 4'h4);
  assign w_dip     = {r_dip_hi, w_hd_data[255:240]};

  always_comb begin
    w_src_found = 1'b0;
    w_src_idx   = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (w_src_sel[i] && !w_src_found) begin
        w_src_found = 1'b1;
        w_src_idx   = 3'(i);
      end
    end
  end

  always_comb begin
    w_mac_hit = 1'b0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (w_src_idx == 3'(p) && w_dst_mac == mac_addr[48*p +: 48]) w_mac_hit = 1'b1;
    end
  end
  // An unknown source port fails even for broadcast destinations
  assign w_port_ok = w_src_found && (32'(w_src_idx) < NUM_PORTS);
  assign w_mac_ok  = w_port_ok && (w_mac_hit || w_dst_mac == '1);

  always_comb begin
    w_dip_hit = 1'b0;
    for (int unsigned t = 0; t < TBL_N; t++) begin
      if (r_tbl[t] != '0 && r_tbl[t] == w_dip) w_dip_hit = 1'b1;
    end
  end

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_RESET) r_state <= HDR0;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_inc_pkt   = 1'b0;
    w_inc_wrong = 1'b0;
    w_inc_nonip = 1'b0;
    w_inc_hit   = 1'b0;
    if (w_pop) begin
      case (r_state)
        HDR0: begin
          w_inc_pkt   = 1'b1;
          w_inc_wrong = !w_mac_ok;
          w_inc_nonip = w_mac_ok && !w_is_ip;
          w_state_nxt = w_hd_last ? HDR0 : HDR1;
        end
        HDR1: begin
          w_inc_hit   = r_mac_ok && r_is_ip && w_dip_hit;
          w_state_nxt = w_hd_last ? HDR0 : BODY;
        end
        BODY:    if (w_hd_last) w_state_nxt = HDR0;
        default: w_state_nxt = HDR0;
      endcase
    end
  end

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_RESET) begin
      r_mac_ok <= 1'b0;
      r_is_ip  <= 1'b0;
      r_dip_hi <= '0;
    end else if (w_pop && r_state == HDR0) begin
      r_mac_ok <= w_mac_ok;
      r_is_ip  <= w_is_ip;
      r_dip_hi <= w_hd_data[15:0];
    end
  end

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_RESET || counter_clear) begin
      pkt_count       <= '0;
      wrong_mac_count <= '0;
      non_ip_count    <= '0;
      dest_hit_count  <= '0;
    end else begin
      pkt_count       <= pkt_count + AW'(w_inc_pkt);
      wrong_mac_count <= wrong_mac_count + AW'(w_inc_wrong);
      non_ip_count    <= non_ip_count + AW'(w_inc_nonip);
      dest_hit_count  <= dest_hit_count + AW'(w_inc_hit);
    end
  end

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_RESET) begin
      for (int unsigned t = 0; t < TBL_N; t++) r_tbl[t] <= '0;
      tbl_rd_data <= '0;
      tbl_rd_ack  <= 1'b0;
      tbl_wr_ack  <= 1'b0;
    end else begin
      tbl_rd_ack <= tbl_rd_req;
      tbl_wr_ack <= tbl_wr_req;
      if (tbl_wr_req) r_tbl[tbl_wr_addr] <= tbl_wr_data;
      if (tbl_rd_req) tbl_rd_data <= r_tbl[tbl_rd_addr];
    end
  end
endmodule
